// File: rtl/csr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : csr_pkg
// Description : Shared constants and types for the machine-mode trap
//               sequencer: CSR addresses, interrupt codes, mstatus bit
//               positions and the sequencer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package csr_pkg;

    // Machine-mode CSR addresses
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    // Interrupt cause codes (also their bit positions in mip/mie)
    localparam logic [3:0] IRQ_CODE_MSI = 4'd3;
    localparam logic [3:0] IRQ_CODE_MTI = 4'd7;
    localparam logic [3:0] IRQ_CODE_MEI = 4'd11;

    // mstatus field positions
    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    // Sequencer states; REDIR is shared by the trap and return paths
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_W_EPC    = 3'd1,
        ST_W_CAUSE  = 3'd2,
        ST_W_STATUS = 3'd3,
        ST_M_STATUS = 3'd4,
        ST_REDIR    = 3'd5
    } trap_state_t;

endpackage : csr_pkg
`default_nettype wire

// File: rtl/csr_irq_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : csr_irq_arbiter
// Description : Combinational interrupt arbiter. Picks the highest-priority
//               pending and enabled interrupt in the order MEI > MSI > MTI.
// Revision    : 1.0 - initial release
// ============================================================================
module csr_irq_arbiter
    import csr_pkg::*;
(
    input  logic [31:0] mip_live,
    input  logic [31:0] mie,
    input  logic        gie,
    output logic        irq_take,
    output logic [3:0]  irq_code
);

    logic [31:0] w_pend;

    assign w_pend = mip_live & mie;

    // Fixed-priority selection; code is only meaningful when irq_take is set
    always_comb begin
        irq_take = gie & (|w_pend);
        irq_code = IRQ_CODE_MTI;
        if (w_pend[IRQ_CODE_MEI]) begin
            irq_code = IRQ_CODE_MEI;
        end else if (w_pend[IRQ_CODE_MSI]) begin
            irq_code = IRQ_CODE_MSI;
        end
    end

endmodule : csr_irq_arbiter
`default_nettype wire

// File: rtl/csr_trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : csr_trap_ctrl
// Description : Machine-mode trap sequencer. Accepts interrupts, exceptions
//               and mret at commit, walks the CSR write port through the
//               mepc / mcause / mstatus updates and issues one PC redirect.
//               Optional macro CSR_VECTORED_EN enables vectored interrupt
//               targets (mtvec mode 2'b01 -> base + 4*code).
// Revision    : 1.0 - initial release
// ============================================================================
module csr_trap_ctrl
    import csr_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            irq_ext,
    input  logic            irq_timer,
    input  logic            irq_sw,
    input  logic            instr_valid,
    input  logic [XLEN-1:0] pc_cur,
    input  logic            exc_valid,
    input  logic [3:0]      exc_code,
    input  logic            mret_valid,
    input  logic [XLEN-1:0] mstatus,
    input  logic [XLEN-1:0] mie,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] mepc,
    output logic [XLEN-1:0] mip_live,
    output logic            csr_wr_en,
    output logic [11:0]     csr_wr_addr,
    output logic [XLEN-1:0] csr_wr_data,
    output logic            stall,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);

    trap_state_t     r_state;
    trap_state_t     w_state_nxt;
    logic [XLEN-1:0] r_epc;
    logic [XLEN-1:0] r_cause;
    logic [XLEN-1:0] r_mstatus;
    logic [XLEN-1:0] r_mtvec;
    logic            r_is_mret;

    logic            w_irq_take;
    logic [3:0]      w_irq_code;
    logic            w_idle;
    logic            w_take_irq;
    logic            w_take_exc;
    logic            w_take_mret;
    logic            w_accept;
    logic [XLEN-1:0] w_status_trap;
    logic [XLEN-1:0] w_status_mret;
    logic [XLEN-1:0] w_trap_target;

    // Live interrupt-pending view built straight from the interrupt lines
    always_comb begin
        mip_live               = '0;
        mip_live[IRQ_CODE_MEI] = irq_ext;
        mip_live[IRQ_CODE_MTI] = irq_timer;
        mip_live[IRQ_CODE_MSI] = irq_sw;
    end

    csr_irq_arbiter u_irq_arbiter (
        .mip_live (mip_live),
        .mie      (mie),
        .gie      (mstatus[MSTATUS_MIE]),
        .irq_take (w_irq_take),
        .irq_code (w_irq_code)
    );

    // Events are only looked at in IDLE, and never in a reset cycle
    assign w_idle      = (r_state == ST_IDLE);
    assign w_take_irq  = w_idle & ~rst & instr_valid & w_irq_take;
    assign w_take_exc  = w_idle & ~rst & instr_valid & exc_valid & ~w_irq_take;
    assign w_take_mret = w_idle & ~rst & instr_valid & mret_valid & ~w_irq_take & ~exc_valid;
    assign w_accept    = w_take_irq | w_take_exc | w_take_mret;
    assign stall       = ~w_idle | w_accept;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Capture event context at acceptance; for mret r_epc holds the target
    always_ff @(posedge clk) begin
        if (rst) begin
            r_epc     <= '0;
            r_cause   <= '0;
            r_mstatus <= '0;
            r_mtvec   <= '0;
            r_is_mret <= 1'b0;
        end else if (w_accept) begin
            r_mstatus <= mstatus;
            r_mtvec   <= mtvec;
            r_is_mret <= w_take_mret;
            r_epc     <= w_take_mret ? mepc : pc_cur;
            if (w_take_irq) begin
                r_cause <= {1'b1, {(XLEN-5){1'b0}}, w_irq_code};
            end else if (w_take_exc) begin
                r_cause <= {{(XLEN-4){1'b0}}, exc_code};
            end else begin
                r_cause <= '0;
            end
        end
    end

    // mstatus images written on trap entry and on return
    always_comb begin
        w_status_trap                               = r_mstatus;
        w_status_trap[MSTATUS_MPIE]                 = r_mstatus[MSTATUS_MIE];
        w_status_trap[MSTATUS_MIE]                  = 1'b0;
        w_status_trap[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;

        w_status_mret                               = r_mstatus;
        w_status_mret[MSTATUS_MIE]                  = r_mstatus[MSTATUS_MPIE];
        w_status_mret[MSTATUS_MPIE]                 = 1'b1;
        w_status_mret[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    end

`ifdef CSR_VECTORED_EN
    // Vectored mode offsets interrupts by 4*code; exceptions use the base
    always_comb begin
        w_trap_target = r_mtvec & ~(XLEN'(3));
        if ((r_mtvec[1:0] == 2'b01) && r_cause[XLEN-1]) begin
            w_trap_target = w_trap_target + XLEN'({r_cause[3:0], 2'b00});
        end
    end
`else
    // Mode bits ignored: every trap lands on the aligned base
    assign w_trap_target = r_mtvec & ~(XLEN'(3));
`endif

    // Next-state and CSR-port / redirect drive
    always_comb begin
        w_state_nxt    = r_state;
        csr_wr_en      = 1'b0;
        csr_wr_addr    = '0;
        csr_wr_data    = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_take_irq | w_take_exc) begin
                    w_state_nxt = ST_W_EPC;
                end else if (w_take_mret) begin
                    w_state_nxt = ST_M_STATUS;
                end
            end
            ST_W_EPC: begin
                csr_wr_en   = 1'b1;
                csr_wr_addr = CSR_MEPC;
                csr_wr_data = {r_epc[XLEN-1:2], 2'b00};
                w_state_nxt = ST_W_CAUSE;
            end
            ST_W_CAUSE: begin
                csr_wr_en   = 1'b1;
                csr_wr_addr = CSR_MCAUSE;
                csr_wr_data = r_cause;
                w_state_nxt = ST_W_STATUS;
            end
            ST_W_STATUS: begin
                csr_wr_en   = 1'b1;
                csr_wr_addr = CSR_MSTATUS;
                csr_wr_data = w_status_trap;
                w_state_nxt = ST_REDIR;
            end
            ST_M_STATUS: begin
                csr_wr_en   = 1'b1;
                csr_wr_addr = CSR_MSTATUS;
                csr_wr_data = w_status_mret;
                w_state_nxt = ST_REDIR;
            end
            ST_REDIR: begin
                redirect_valid = 1'b1;
                redirect_pc    = r_is_mret ? r_epc : w_trap_target;
                w_state_nxt    = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule : csr_trap_ctrl
`default_nettype wire

// File: tb/tb_csr_trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_csr_trap_ctrl
// Description : Self-checking bench for csr_trap_ctrl. A behavioural model
//               turns each accepted event into a queue of expected per-cycle
//               port values; directed scenarios pin literal values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_csr_trap_ctrl;

    typedef struct {
        logic        we;
        logic [11:0] a;
        logic [31:0] d;
        logic        rv;
        logic [31:0] rp;
        logic        st;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        irq_ext, irq_timer, irq_sw;
    logic        instr_valid;
    logic [31:0] pc_cur;
    logic        exc_valid;
    logic [3:0]  exc_code;
    logic        mret_valid;
    logic [31:0] mstatus, mie, mtvec, mepc;
    logic [31:0] mip_live;
    logic        csr_wr_en;
    logic [11:0] csr_wr_addr;
    logic [31:0] csr_wr_data;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int n_checks = 0;
    int n_errors = 0;
    exp_t q[$];

    csr_trap_ctrl #(.XLEN(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .irq_ext        (irq_ext),
        .irq_timer      (irq_timer),
        .irq_sw         (irq_sw),
        .instr_valid    (instr_valid),
        .pc_cur         (pc_cur),
        .exc_valid      (exc_valid),
        .exc_code       (exc_code),
        .mret_valid     (mret_valid),
        .mstatus        (mstatus),
        .mie            (mie),
        .mtvec          (mtvec),
        .mepc           (mepc),
        .mip_live       (mip_live),
        .csr_wr_en      (csr_wr_en),
        .csr_wr_addr    (csr_wr_addr),
        .csr_wr_data    (csr_wr_data),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic void push_trap(input logic [31:0] pc, input logic [31:0] cause,
                                      input logic [31:0] ms, input logic [31:0] tgt);
        logic [31:0] ms_new;
        ms_new = (ms & ~32'h0000_1888) | 32'h0000_1800 | (ms[3] ? 32'h80 : 32'h0);
        q.push_back('{1'b1, 12'h341, pc & ~32'h3, 1'b0, 32'h0, 1'b1});
        q.push_back('{1'b1, 12'h342, cause,       1'b0, 32'h0, 1'b1});
        q.push_back('{1'b1, 12'h300, ms_new,      1'b0, 32'h0, 1'b1});
        q.push_back('{1'b0, 12'h000, 32'h0,       1'b1, tgt,   1'b1});
    endfunction

    // Reference model: per-cycle expectations derived from the trap rules
    always @(negedge clk) begin : model
        exp_t        e;
        logic        ie, it, is;
        logic [3:0]  code;
        logic [31:0] tgt, ms;
        chk("mip_live", mip_live,
            {20'b0, irq_ext, 3'b0, irq_timer, 3'b0, irq_sw, 3'b0});
        if (rst) begin
            q.delete();
        end else begin
            if (q.size() > 0) begin
                e = q.pop_front();
            end else begin
                e = '{1'b0, 12'h0, 32'h0, 1'b0, 32'h0, 1'b0};
                ie = irq_ext & mie[11];
                it = irq_timer & mie[7];
                is = irq_sw & mie[3];
                if (instr_valid && mstatus[3] && (ie || it || is)) begin
                    code = ie ? 4'd11 : (is ? 4'd3 : 4'd7);
                    tgt  = mtvec & ~32'h3;
`ifdef CSR_VECTORED_EN
                    if (mtvec[1:0] == 2'b01) tgt = tgt + 32'(code) * 4;
`endif
                    push_trap(pc_cur, 32'h8000_0000 | 32'(code), mstatus, tgt);
                    e.st = 1'b1;
                end else if (instr_valid && exc_valid) begin
                    push_trap(pc_cur, 32'(exc_code), mstatus, mtvec & ~32'h3);
                    e.st = 1'b1;
                end else if (instr_valid && mret_valid) begin
                    ms = (mstatus & ~32'h0000_1888) | 32'h0000_1880 | (mstatus[7] ? 32'h8 : 32'h0);
                    q.push_back('{1'b1, 12'h300, ms,    1'b0, 32'h0, 1'b1});
                    q.push_back('{1'b0, 12'h000, 32'h0, 1'b1, mepc,  1'b1});
                    e.st = 1'b1;
                end
            end
            chk("model.wr_en",  32'(csr_wr_en),      32'(e.we));
            chk("model.wr_addr", 32'(csr_wr_addr),   32'(e.a));
            chk("model.wr_data", csr_wr_data,        e.d);
            chk("model.redir_v", 32'(redirect_valid), 32'(e.rv));
            chk("model.redir_pc", redirect_pc,       e.rp);
            chk("model.stall",  32'(stall),          32'(e.st));
        end
    end

    // One cycle of literal checks, returning at the next cycle's drive point
    task automatic cyc(input string nm, input logic we, input logic [11:0] a,
                       input logic [31:0] d, input logic rv, input logic [31:0] rp,
                       input logic st);
        @(negedge clk);
        chk({nm, ".wr_en"},   32'(csr_wr_en),      32'(we));
        chk({nm, ".wr_addr"}, 32'(csr_wr_addr),    32'(a));
        chk({nm, ".wr_data"}, csr_wr_data,         d);
        chk({nm, ".redir_v"}, 32'(redirect_valid), 32'(rv));
        chk({nm, ".redir_pc"}, redirect_pc,        rp);
        chk({nm, ".stall"},   32'(stall),          32'(st));
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        irq_ext = 0; irq_timer = 0; irq_sw = 0;
        instr_valid = 0; exc_valid = 0; mret_valid = 0; exc_code = 0;
    endtask

    initial begin
        logic [31:0] vec_tgt;
        quiet();
        pc_cur = 0; mstatus = 0; mie = 0; mtvec = 0; mepc = 0;
        rst = 1;
        @(posedge clk); #1;
        cyc("reset", 0, 12'h0, 32'h0, 0, 32'h0, 0);
        @(posedge clk); #1;
        rst = 0;
        cyc("post_reset", 0, 12'h0, 32'h0, 0, 32'h0, 0);

        // Timer interrupt, direct mode
        mstatus = 32'h8; mie = 32'h80; mtvec = 32'h100; pc_cur = 32'h40;
        irq_timer = 1; instr_valid = 1;
        cyc("tmr.c0", 0, 12'h0, 32'h0, 0, 32'h0, 1);
        quiet();
        cyc("tmr.c1", 1, 12'h341, 32'h40,        0, 32'h0,   1);
        cyc("tmr.c2", 1, 12'h342, 32'h8000_0007, 0, 32'h0,   1);
        cyc("tmr.c3", 1, 12'h300, 32'h1880,      0, 32'h0,   1);
        cyc("tmr.c4", 0, 12'h0,   32'h0,         1, 32'h100, 1);
        cyc("tmr.c5", 0, 12'h0,   32'h0,         0, 32'h0,   0);

        // MEI beats MTI; vectored target when the feature is built in
        mstatus = 32'h8; mie = 32'h880; mtvec = 32'h101; pc_cur = 32'h40;
        irq_ext = 1; irq_timer = 1; instr_valid = 1;
`ifdef CSR_VECTORED_EN
        vec_tgt = 32'h12C;
`else
        vec_tgt = 32'h100;
`endif
        cyc("vec.c0", 0, 12'h0, 32'h0, 0, 32'h0, 1);
        quiet();
        cyc("vec.c1", 1, 12'h341, 32'h40,        0, 32'h0, 1);
        cyc("vec.c2", 1, 12'h342, 32'h8000_000B, 0, 32'h0, 1);
        cyc("vec.c3", 1, 12'h300, 32'h1880,      0, 32'h0, 1);
        cyc("vec.c4", 0, 12'h0,   32'h0,         1, vec_tgt, 1);

        // ecall exception, unaligned low bits in mtvec stripped
        mstatus = 32'h0; mie = 32'h0; mtvec = 32'h103; pc_cur = 32'h200;
        exc_valid = 1; exc_code = 4'd11; instr_valid = 1;
        cyc("exc.c0", 0, 12'h0, 32'h0, 0, 32'h0, 1);
        quiet();
        cyc("exc.c1", 1, 12'h341, 32'h200,  0, 32'h0,   1);
        cyc("exc.c2", 1, 12'h342, 32'hB,    0, 32'h0,   1);
        cyc("exc.c3", 1, 12'h300, 32'h1800, 0, 32'h0,   1);
        cyc("exc.c4", 0, 12'h0,   32'h0,    1, 32'h100, 1);

        // mret
        mstatus = 32'h1880; mepc = 32'h44; mret_valid = 1; instr_valid = 1;
        cyc("mret.c0", 0, 12'h0, 32'h0, 0, 32'h0, 1);
        quiet();
        cyc("mret.c1", 1, 12'h300, 32'h1888, 0, 32'h0,  1);
        cyc("mret.c2", 0, 12'h0,   32'h0,    1, 32'h44, 1);
        cyc("mret.c3", 0, 12'h0,   32'h0,    0, 32'h0,  0);

        // Masking: global disable, then no committing instruction
        mstatus = 32'h0; mie = 32'h80; mtvec = 32'h100; irq_timer = 1; instr_valid = 1;
        cyc("mask.gie", 0, 12'h0, 32'h0, 0, 32'h0, 0);
        mstatus = 32'h8; instr_valid = 0;
        cyc("mask.iv",  0, 12'h0, 32'h0, 0, 32'h0, 0);
        quiet();

        // Reset asserted while in W_CAUSE
        mstatus = 32'h8; mie = 32'h80; pc_cur = 32'h80; irq_timer = 1; instr_valid = 1;
        cyc("rst.c0", 0, 12'h0, 32'h0, 0, 32'h0, 1);
        quiet();
        cyc("rst.c1", 1, 12'h341, 32'h80, 0, 32'h0, 1);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        cyc("rst.c3", 0, 12'h0, 32'h0, 0, 32'h0, 0);
        cyc("rst.c4", 0, 12'h0, 32'h0, 0, 32'h0, 0);
        cyc("rst.c5", 0, 12'h0, 32'h0, 0, 32'h0, 0);

        // Randomized traffic, checked every cycle by the model
        for (int i = 0; i < 4000; i++) begin
            rst         = ($urandom_range(0, 299) == 0);
            instr_valid = ($urandom_range(0, 3) != 0);
            exc_valid   = ($urandom_range(0, 5) == 0);
            mret_valid  = ($urandom_range(0, 5) == 0);
            exc_code    = 4'($urandom);
            irq_ext     = ($urandom_range(0, 4) == 0);
            irq_timer   = ($urandom_range(0, 4) == 0);
            irq_sw      = ($urandom_range(0, 4) == 0);
            mstatus     = $urandom;
            mie         = $urandom;
            mtvec       = {$urandom_range(0, 32'h00FF_FFFF), 6'b0, 1'b0, 1'($urandom)};
            if ($urandom_range(0, 3) == 0) mtvec = mtvec | 32'hFFFF_FF00;
            pc_cur      = $urandom;
            mepc        = $urandom;
            @(posedge clk); #1;
        end
        rst = 0;
        quiet();
        repeat (6) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_csr_trap_ctrl
`default_nettype wire
